// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit owning the HI/LO result registers.
//
// Multiply is radix-2 shift-add and divide is restoring division. Both work on
// operand magnitudes, retire one bit per cycle for WIDTH cycles, and fix up the
// result signs on the final iteration edge.
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   synchronous active-high reset
//   start     in   operation request, only looked at in IDLE
//   op        in   0 = multiply, 1 = divide
//   sign      in   1 = signed operands, 0 = unsigned
//   a         in   multiplicand / dividend (WIDTH)
//   b         in   multiplier / divisor (WIDTH)
//   busy      out  operation in progress (MULT, DIV, DONE)
//   done      out  one-cycle completion pulse
//   div_zero  out  one-cycle pulse alongside done when the divisor was zero
//   hi        out  product upper half / remainder (WIDTH)
//   lo        out  product lower half / quotient (WIDTH)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; hi/lo hold the last result
// MULT  | shift-add iterations, one multiplier bit per cycle
// DIV   | restoring-division iterations, one quotient bit per cycle
// DONE  | one-cycle completion (done, plus div_zero when flagged)
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  if ((2 ** CNT_W) <= WIDTH) begin : g_cnt_w_check
    $error("mult_div_unit: CNT_W too small to count WIDTH iterations");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   opnd;       // multiplicand magnitude or divisor magnitude
  logic [2*WIDTH-1:0] acc;        // mult: {partial sum, multiplier}; div: {remainder, dividend/quotient}
  logic               neg_res;    // product / quotient must be negated
  logic               neg_rem;    // remainder must be negated
  logic               dz_flag;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               last_iter;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] acc_step;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // The most-negative value maps to itself under negation, which still reads
  // correctly as an unsigned magnitude of 2^(WIDTH-1).
  assign mag_a = (sign && a[WIDTH-1]) ? -a : a;
  assign mag_b = (sign && b[WIDTH-1]) ? -b : b;

  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // One shift-add step: add the multiplicand into the upper half when the
  // current multiplier bit is set, then shift the whole accumulator right.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // One restoring-division step: shift the next dividend bit into the
  // remainder and subtract the divisor if it fits.
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd};
  assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};

  assign acc_step = (state == MULT) ? mul_next : div_next;

  assign prod_fix = neg_res ? -acc_step : acc_step;
  assign quo_fix  = neg_res ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
  assign rem_fix  = neg_rem ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    div_zero  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (!op) begin
            state_nxt = MULT;
          end else if (b == '0) begin
            state_nxt = DONE;
          end else begin
            state_nxt = DIV;
          end
        end
      end
      MULT, DIV: begin
        busy = 1'b1;
        if (last_iter) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        div_zero  = dz_flag;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      opnd    <= '0;
      acc     <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      dz_flag <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt     <= '0;
            neg_res <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem <= sign & a[WIDTH-1];
            dz_flag <= op && (b == '0);
            if (op) begin
              opnd <= mag_b;
              acc  <= {{WIDTH{1'b0}}, mag_a};
            end else begin
              opnd <= mag_a;
              acc  <= {{WIDTH{1'b0}}, mag_b};
            end
          end
        end
        MULT, DIV: begin
          acc <= acc_step;
          if (last_iter) begin
            cnt <= '0;
            if (state == MULT) begin
              {hi, lo} <= prod_fix;
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          dz_flag <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: table-driven and randomised checks of mult_div_unit, with a
// scoreboard queue of expected results popped on each done pulse.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic         op;
  logic         sign;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .sign     (sign),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic         op;
    logic         sign;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } vec_t;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           due;
  } exp_t;

  vec_t vecs[12];
  exp_t sb_q[$];

  int n_chk  = 0;
  int n_fail = 0;
  logic         mon_en = 1'b0;
  logic [W-1:0] cur_hi = '0;
  logic [W-1:0] cur_lo = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference results from the language's own 64-bit arithmetic.
  task automatic model(input logic o, input logic s, input logic [W-1:0] va, input logic [W-1:0] vb,
                       output logic [W-1:0] eh, output logic [W-1:0] el, output logic edz);
    logic signed [63:0] sa, sb, sr;
    logic [63:0] up;
    edz = 1'b0;
    eh  = cur_hi;
    el  = cur_lo;
    sa  = $signed(va);
    sb  = $signed(vb);
    if (!o) begin
      if (s) begin
        sr = sa * sb;
        {eh, el} = sr;
      end else begin
        up = {32'b0, va} * {32'b0, vb};
        {eh, el} = up;
      end
    end else if (vb == '0) begin
      edz = 1'b1;
    end else if (s) begin
      sr = sa / sb;
      el = sr[W-1:0];
      sr = sa % sb;
      eh = sr[W-1:0];
    end else begin
      el = va / vb;
      eh = va % vb;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (done) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("hi", hi, e.hi);
          chk("lo", lo, e.lo);
          chk("div_zero", div_zero, e.dz);
          chk("latency", cyc, e.due);
          cur_hi = e.hi;
          cur_lo = e.lo;
        end
      end else begin
        chk("hi_stable", hi, cur_hi);
        chk("lo_stable", lo, cur_lo);
        chk("div_zero_idle", div_zero, 0);
      end
    end
  end

  task automatic issue_op(input logic o, input logic s, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic push, input logic [W-1:0] eh, input logic [W-1:0] el,
                          input logic edz);
    exp_t e;
    @(negedge clk);
    op = o; sign = s; a = va; b = vb; start = 1'b1;
    @(posedge clk);
    #1;
    if (push) begin
      e.hi  = eh;
      e.lo  = el;
      e.dz  = edz;
      e.due = cyc + (edz ? 0 : W);
      sb_q.push_back(e);
    end
    start = 1'b0;
    op    = 1'($urandom);
    sign  = 1'($urandom);
    a     = $urandom;
    b     = $urandom;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (sb_q.size() == 0 && !busy) ok = 1'b1;
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: got busy=%0b pending=%0d expected idle", busy, sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [W-1:0] eh, el, ra, rb;
    logic         edz, ro, rs;

    vecs[0]  = '{1'b0, 1'b1, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'h7FFFFFFF, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 32'd1234,     32'd0,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 32'd0,        32'h12345,    32'h00000000, 32'h00000000, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 32'd5,        32'd7,        32'h00000005, 32'h00000000, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 32'hFFFFFFF9, 32'd0,        32'h40000000, 32'h00000000, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};

    reset = 1'b1; start = 1'b0; op = 1'b0; sign = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_div_zero", div_zero, 0);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 12; i++) begin
      issue_op(vecs[i].op, vecs[i].sign, vecs[i].a, vecs[i].b, 1'b1, vecs[i].hi, vecs[i].lo, vecs[i].dz);
      wait_idle();
    end

    for (int i = 0; i < 24; i++) begin
      ro = 1'($urandom);
      rs = 1'($urandom);
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
      if (i % 5 == 0) rb = rb >> $urandom_range(0, 31);
      model(ro, rs, ra, rb, eh, el, edz);
      issue_op(ro, rs, ra, rb, 1'b1, eh, el, edz);
      wait_idle();
    end

    // Signed overflow, with a stray start a few cycles into the operation.
    issue_op(1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h80000000, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    op = 1'b0; sign = 1'b0; a = 32'd3; b = 32'd5; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_mid_op", busy, 1);
    wait_idle();

    // A start held during the DONE cycle must be dropped.
    issue_op(1'b0, 1'b0, 32'd2, 32'd3, 1'b1, 32'd0, 32'd6, 1'b0);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
        @(negedge clk);
        if (done) seen = 1'b1;
      end
      chk("done_seen", seen, 1);
    end
    op = 1'b0; sign = 1'b0; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("start_in_done_ignored", busy, 0);
    wait_idle();

    // Reset at iteration 10 of a multiply: no done, results cleared.
    issue_op(1'b0, 1'b0, 32'h1234, 32'h5678, 1'b0, '0, '0, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    cur_hi = '0;
    cur_lo = '0;
    chk("reset_mid_busy", busy, 0);
    chk("reset_mid_done", done, 0);
    chk("reset_mid_hi", hi, 0);
    chk("reset_mid_lo", lo, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(posedge clk);

    issue_op(1'b1, 1'b0, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b0);
    wait_idle();
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Parametrised iterative multiply/divide unit, driven by the multicycle control unit through MultCtrl/DivCtrl-style start pulses, and owning the HI/LO result registers read by MFHI/MFLO. It supports signed and unsigned operation (MULT/MULTU, DIV/DIVU), a start/done handshake with a busy flag, and divide-by-zero reporting for the exception path. Operands come from the register file A/B outputs; results stay in HI/LO until the next operation completes.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request pulse; sampled only in IDLE
op  input  1  0 = multiply, 1 = divide
sign  input  1  1 = signed operands, 0 = unsigned
a  input  WIDTH  multiplicand / dividend
b  input  WIDTH  multiplier / divisor
busy  output  1  high in MULT, DIV and DONE states
done  output  1  single-cycle completion pulse
div_zero  output  1  single-cycle pulse, coincident with done, when divisor is 0
hi  output  WIDTH  multiply: upper product half; divide: remainder
lo  output  WIDTH  multiply: lower product half; divide: quotient

Behaviour:
- Clock port is clk; reset is synchronous, active-high, named reset; reset has priority over every other input.
- Reset values: state = IDLE, busy = 0, done = 0, div_zero = 0, hi = 0, lo = 0, counter = 0.
- States: IDLE, MULT, DIV, DONE.
- IDLE with start = 1 at edge k: latch operand magnitudes, result-sign flags and op.
  - op = 0: go to MULT.
  - op = 1 and b != 0: go to DIV.
  - op = 1 and b == 0: go directly to DONE with the div_zero flag set. No iteration runs.
- Signed mode (sign = 1): operate on magnitudes.
  - Product sign = a[MSB] xor b[MSB].
  - Quotient sign = a[MSB] xor b[MSB]; remainder sign = a[MSB].
  - Quotient truncates toward zero.
- Unsigned mode (sign = 0): operands are used as-is.
- MULT: radix-2 shift-add on magnitudes, one bit per cycle, WIDTH cycles (edges k+1..k+WIDTH), producing a 2*WIDTH-bit product.
- DIV: restoring division on magnitudes, one quotient bit per cycle, WIDTH cycles (edges k+1..k+WIDTH).
- Leaving MULT/DIV on the final iteration edge (k+WIDTH): sign-correct the result, write hi/lo, enter DONE.
- Result writes:
  - Multiply: {hi, lo} = full 2*WIDTH-bit product.
  - Divide: lo = quotient, hi = remainder.
- DONE lasts exactly one cycle: done = 1 (plus div_zero = 1 if flagged), then IDLE.
- Latency:
  - Normal operation: done is high during the cycle after edge k+WIDTH, i.e. WIDTH+1 cycles after the start edge.
  - Divide by zero: done is high during the cycle after edge k.
- Divide by zero: hi and lo keep their previous values.
- Signed overflow (a = most-negative value, b = -1): lo = most-negative value, hi = 0; no flag raised.
- start while busy = 1 (including in DONE): ignored, no queuing. A start in the cycle after DONE (state back in IDLE) is accepted normally.
- Operand inputs are not required to be stable after the start edge; all operands are latched internally.
- hi/lo change only on the final-iteration edge or on reset; they are stable throughout MULT/DIV.
- Reset during MULT/DIV/DONE: return to IDLE, clear hi/lo, no done pulse.
- Counter counts 0..WIDTH-1 and does not wrap beyond that; the 2^CNT_W > WIDTH constraint is checked at elaboration.

Test Plan:
- Signed multiply: a = 7, b = 0xFFFFFFFD (-3), sign = 1, op = 0 -> done pulse 33 cycles after start; hi = 0xFFFFFFFF, lo = 0xFFFFFFEB.
- Unsigned multiply: a = b = 0xFFFFFFFF, sign = 0 -> hi = 0xFFFFFFFE, lo = 0x00000001.
- Signed divide: a = 0xFFFFFFF9 (-7), b = 2, sign = 1, op = 1 -> lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1).
- Unsigned divide: a = 0xFFFFFFFF, b = 2, sign = 0 -> lo = 0x7FFFFFFF, hi = 1.
- Divide by zero:
  - Stimulus: preload hi/lo with a multiply; then divide with b = 0.
  - Response: done and div_zero both high in the cycle after start; hi/lo unchanged.
- Overflow, busy and reset:
  - Signed 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
  - A second start at cycle 5 of that operation is ignored.
  - A reset asserted at iteration 10 of a new operation -> IDLE next cycle, hi = lo = 0, no done pulse.
